fwd_stall_unit: RTL

//  Parametrised hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W): it replaces the fixed 2-port forwarding muxes.

---
 rtl/fwd_pkg.sv | 18 +
 rtl/fwd_port_mux.sv | 67 ++++++
 rtl/fwd_stall_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / stall unit.
// Default widths match the 5-stage MIPS datapath.
package fwd_pkg;

  localparam int REG_W_DEF  = 5;
  localparam int DATA_W_DEF = 32;

  typedef logic [REG_W_DEF-1:0]  creg_addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    FWD_ZERO,
    FWD_M,
    FWD_W,
    FWD_REG
  } fwd_sel_e;

endpackage

// File: rtl/fwd_port_mux.sv
// One bypass mux for a single register read port.
// Also reports whether the port matches the E or M producer.
module fwd_port_mux
  import fwd_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [REG_W-1:0]  ra,
  input  logic [DATA_W-1:0] rval,
  input  logic [REG_W-1:0]  e_wr,
  input  logic              e_we,
  input  logic [REG_W-1:0]  m_wr,
  input  logic              m_we,
  input  logic              m_load,
  input  logic [DATA_W-1:0] m_aluout,
  input  logic [REG_W-1:0]  w_wr,
  input  logic              w_we,
  input  logic [DATA_W-1:0] w_val,
  output logic [DATA_W-1:0] fwd,
  output logic              hit_e,
  output logic              hit_m
);

  logic     nz;
  logic     hit_w;
  logic     m_fwd;
  logic     w_fwd;
  fwd_sel_e sel;

  assign nz    = |ra;
  assign hit_e = nz && e_we && (e_wr == ra);
  assign hit_m = nz && m_we && (m_wr == ra);
  assign hit_w = nz && w_we && (w_wr == ra);

`ifdef FWD_BYPASS_EN
  // a load in M has no data yet; W may still supply an older value
  assign m_fwd = hit_m && !m_load;
`else
  logic unused_m_load;
  assign unused_m_load = m_load;
  assign m_fwd = 1'b0;
`endif

  assign w_fwd = hit_w && !m_fwd;

  always_comb begin
    sel = FWD_REG;
    unique case (1'b1)
      !nz:     sel = FWD_ZERO;
      m_fwd:   sel = FWD_M;
      w_fwd:   sel = FWD_W;
      default: sel = FWD_REG;
    endcase
  end

  always_comb begin
    fwd = rval;
    case (sel)
      FWD_ZERO: fwd = '0;
      FWD_M:    fwd = m_aluout;
      FWD_W:    fwd = w_val;
      default:  fwd = rval;
    endcase
  end

endmodule

// File: rtl/fwd_stall_unit.sv
// N-port bypass, load-use / branch stall and MDU busy tracking.
// FWD_BYPASS_EN enables M-stage forwarding; undefined stalls on E/M deps.
module fwd_stall_unit
  import fwd_pkg::*;
#(
  parameter int NRD     = 2,
  parameter int NRE     = 2,
  parameter int REG_W   = REG_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MDU_LAT = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NRD*REG_W-1:0]  d_ra,
  input  logic [NRD-1:0]        d_rv,
  input  logic [NRD*DATA_W-1:0] d_val,
  input  logic                  d_br,
  input  logic                  d_mdu,
  input  logic                  d_hilo,
  input  logic [NRE*REG_W-1:0]  e_ra,
  input  logic [NRE*DATA_W-1:0] e_val,
  input  logic [REG_W-1:0]      e_wr,
  input  logic                  e_we,
  input  logic                  e_load,
  input  logic [REG_W-1:0]      m_wr,
  input  logic                  m_we,
  input  logic                  m_load,
  input  logic [DATA_W-1:0]     m_aluout,
  input  logic [REG_W-1:0]      w_wr,
  input  logic                  w_we,
  input  logic [DATA_W-1:0]     w_val,
  output logic [NRD*DATA_W-1:0] d_fwd,
  output logic [NRE*DATA_W-1:0] e_fwd,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_e,
  output logic                  mdu_busy
);

  localparam int CW = $clog2(MDU_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MDU_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {
    MDU_IDLE,
    MDU_BUSY
  } mdu_st_e;

  logic [NRD-1:0] d_hit_e;
  logic [NRD-1:0] d_hit_m;
  logic [NRE-1:0] e_hit_e;
  logic [NRE-1:0] e_hit_m;

  mdu_st_e        state;
  logic [CW-1:0]  cnt;

  logic load_use;
  logic br_haz;
  logic dep_haz;
  logic mdu_haz;
  logic haz;

  for (genvar p = 0; p < NRD; p++) begin : g_d
    fwd_port_mux #(
      .REG_W  (REG_W),
      .DATA_W (DATA_W)
    ) u_mux (
      .ra       (d_ra[p*REG_W +: REG_W]),
      .rval     (d_val[p*DATA_W +: DATA_W]),
      .e_wr     (e_wr),
      .e_we     (e_we),
      .m_wr     (m_wr),
      .m_we     (m_we),
      .m_load   (m_load),
      .m_aluout (m_aluout),
      .w_wr     (w_wr),
      .w_we     (w_we),
      .w_val    (w_val),
      .fwd      (d_fwd[p*DATA_W +: DATA_W]),
      .hit_e    (d_hit_e[p]),
      .hit_m    (d_hit_m[p])
    );
  end

  for (genvar p = 0; p < NRE; p++) begin : g_e
    fwd_port_mux #(
      .REG_W  (REG_W),
      .DATA_W (DATA_W)
    ) u_mux (
      .ra       (e_ra[p*REG_W +: REG_W]),
      .rval     (e_val[p*DATA_W +: DATA_W]),
      .e_wr     (e_wr),
      .e_we     (e_we),
      .m_wr     (m_wr),
      .m_we     (m_we),
      .m_load   (m_load),
      .m_aluout (m_aluout),
      .w_wr     (w_wr),
      .w_we     (w_we),
      .w_val    (w_val),
      .fwd      (e_fwd[p*DATA_W +: DATA_W]),
      .hit_e    (e_hit_e[p]),
      .hit_m    (e_hit_m[p])
    );
  end

  // E operands are already past the point where a stall helps
  logic unused_e_hits;
  assign unused_e_hits = ^{e_hit_e, e_hit_m};

`ifdef FWD_BYPASS_EN
  assign load_use = e_load && |(d_rv & d_hit_e);
  assign br_haz   = d_br &&
                    |(d_rv & (d_hit_e | (d_hit_m & {NRD{m_load}})));
  assign dep_haz  = 1'b0;
`else
  logic unused_cfg;
  assign unused_cfg = ^{e_load, d_br};
  assign load_use   = 1'b0;
  assign br_haz     = 1'b0;
  assign dep_haz    = |(d_rv & (d_hit_e | d_hit_m));
`endif

  assign mdu_haz = (d_mdu || d_hilo) && (cnt != '0);
  assign haz     = resetn &&
                   (load_use || br_haz || dep_haz || mdu_haz);

  assign stall_f = haz;
  assign stall_d = haz;
  assign flush_e = haz;

  // countdown runs through stalls; only a fresh issue reloads it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= MDU_IDLE;
      cnt      <= '0;
      mdu_busy <= 1'b0;
    end else begin
      unique case (state)
        MDU_IDLE: begin
          if (d_mdu && !stall_d) begin
            state    <= MDU_BUSY;
            cnt      <= LAT;
            mdu_busy <= 1'b1;
          end
        end
        MDU_BUSY: begin
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            state    <= MDU_IDLE;
            mdu_busy <= 1'b0;
          end
        end
        default: begin
          state    <= MDU_IDLE;
          cnt      <= '0;
          mdu_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
